// File: rtl/biu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : biu_pkg                                                 |
// | Description: Shared types and elaboration helpers for the bus        |
// |              interface unit sequencer: bus-cycle state encoding,     |
// |              beat-count and counter-width functions.                 |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package biu_pkg;

  // Bus-cycle states. T3 also serves as the wait state (TW).
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4
  } biu_state_e;

  // Number of external bus beats needed for one core-width word.
  function automatic int beats_f(input int cpu_w, input int bus_w);
    return cpu_w / bus_w;
  endfunction

  // Bits needed to represent every value 0..max_val (never below 1).
  function automatic int cnt_w_f(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/biu_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface  : biu_sequencer_if                                        |
// | Description: Core-side request/response bundle of the BIU sequencer. |
// |              master = core (issues requests), slave = sequencer.     |
// | Ports      : req_valid/req_ready handshake, req_we, req_byte,        |
// |              req_addr, req_wdata; busy, done, err, rdata back.       |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface biu_sequencer_if #(
  parameter int ADDR_W = 20,
  parameter int CPU_W  = 16
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [CPU_W-1:0]  req_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [CPU_W-1:0]  rdata;

  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata,
    input  req_ready, busy, done, err, rdata
  );

  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata,
    output req_ready, busy, done, err, rdata
  );

endinterface
`default_nettype wire

// File: rtl/biu_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : biu_counter                                             |
// | Description: Small up-counter with synchronous clear (priority) and  |
// |              increment enable; used for beat and wait counting.      |
// | Ports      : clk, rst (async, active-low), clr, inc -> q             |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module biu_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/biu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : biu_sequencer                                           |
// | Description: Bus interface unit sequencer. Splits a core word access |
// |              into BUS_W-wide T1..T4 bus cycles (T3 doubles as the    |
// |              wait state), assembles read data, and flags a timeout   |
// |              abort when MAX_WAIT wait states elapse.                 |
// | Ports      : clk, rst (async, active-low)                            |
// |              bif      - core request/response (slave modport)        |
// |              addr_o   - bus address, ale - address latch enable      |
// |              rd_n, wr_n, den_n - active-low strobes                  |
// |              dtr      - 1 = CPU drives the bus                       |
// |              bus_ready, bus_din, bus_dout, bus_oe - data bus         |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
// The interface instance must be built with the same ADDR_W/CPU_W values.
// CPU_W must be an integer multiple of BUS_W, and BUS_W <= ADDR_W.
module biu_sequencer
  import biu_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int CPU_W    = 16,
  parameter int BUS_W    = 8,
  parameter int MAX_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  biu_sequencer_if.slave    bif,
  output logic [ADDR_W-1:0] addr_o,
  output logic              ale,
  output logic              rd_n,
  output logic              wr_n,
  output logic              den_n,
  output logic              dtr,
  input  logic              bus_ready,
  input  logic [BUS_W-1:0]  bus_din,
  output logic [BUS_W-1:0]  bus_dout,
  output logic              bus_oe
);

  localparam int BEATS  = beats_f(CPU_W, BUS_W);
  // The beat counter reaches BEATS on the final T4, so size it for that.
  localparam int BEAT_W = cnt_w_f(BEATS);
  localparam int WAIT_W = cnt_w_f((MAX_WAIT > 0) ? MAX_WAIT : 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(MAX_WAIT);

  biu_state_e        state;
  logic              we_q;
  logic              byte_q;
  logic              abort_q;
  logic [CPU_W-1:0]  wdata_sh;   // beat data shifted down so the current beat sits in the LSBs
  logic [BEAT_W-1:0] beat;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] next_addr;
  logic              accept;
  logic              last_beat;
  logic              timeout;
  logic              beat_clr;
  logic              beat_inc;
  logic              wait_clr;
  logic              wait_inc;

  assign accept    = bif.req_valid & (state == ST_IDLE);
  assign last_beat = byte_q | (beat == LAST_BEAT);
  assign next_addr = addr_o + ADDR_W'(1);

  // Abort only when the limit is reached and the slave is still not ready;
  // a ready on the limit cycle completes normally.
  assign timeout   = (MAX_WAIT > 0) && !bus_ready && (wait_cnt == WAIT_LIM);

  assign beat_clr  = accept;
  assign beat_inc  = (state == ST_T4);
  // Wait limit applies per bus cycle, so the count restarts every beat.
  assign wait_clr  = accept | (state == ST_T4);
  assign wait_inc  = (state == ST_T3) & ~bus_ready & ~timeout;

  biu_counter #(.WIDTH(BEAT_W)) u_beat_cnt (
    .clk (clk),
    .rst (rst),
    .clr (beat_clr),
    .inc (beat_inc),
    .q   (beat)
  );

  biu_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (wait_clr),
    .inc (wait_inc),
    .q   (wait_cnt)
  );

  // Outputs are registered: every transition loads the output values that
  // belong to the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      we_q          <= 1'b0;
      byte_q        <= 1'b0;
      abort_q       <= 1'b0;
      wdata_sh      <= '0;
      addr_o        <= '0;
      ale           <= 1'b0;
      rd_n          <= 1'b1;
      wr_n          <= 1'b1;
      den_n         <= 1'b1;
      dtr           <= 1'b1;
      bus_oe        <= 1'b0;
      bus_dout      <= '0;
      bif.req_ready <= 1'b1;
      bif.busy      <= 1'b0;
      bif.done      <= 1'b0;
      bif.err       <= 1'b0;
      bif.rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state         <= ST_T1;
            we_q          <= bif.req_we;
            byte_q        <= bif.req_byte;
            abort_q       <= 1'b0;
            wdata_sh      <= bif.req_wdata;
            addr_o        <= bif.req_addr;
            ale           <= 1'b1;
            bus_oe        <= 1'b1;
            bus_dout      <= bif.req_addr[BUS_W-1:0];
            dtr           <= bif.req_we;
            bif.req_ready <= 1'b0;
            bif.busy      <= 1'b1;
          end
        end

        ST_T1: begin
          state  <= ST_T2;
          ale    <= 1'b0;
          den_n  <= 1'b0;
          rd_n   <= we_q;
          wr_n   <= ~we_q;
          dtr    <= we_q;
          bus_oe <= we_q;
          if (we_q) begin
            bus_dout <= wdata_sh[BUS_W-1:0];
          end
        end

        ST_T2: begin
          state <= ST_T3;
        end

        ST_T3: begin
          if (bus_ready || timeout) begin
            state    <= ST_T4;
            rd_n     <= 1'b1;
            wr_n     <= 1'b1;
            den_n    <= 1'b1;
            abort_q  <= timeout;
            bif.done <= last_beat | timeout;
            bif.err  <= timeout;
            if (bus_ready && !we_q) begin
              bif.rdata[BUS_W*int'(beat) +: BUS_W] <= bus_din;
            end
          end
        end

        ST_T4: begin
          bif.done <= 1'b0;
          bif.err  <= 1'b0;
          if (!last_beat && !abort_q) begin
            state    <= ST_T1;
            addr_o   <= next_addr;
            ale      <= 1'b1;
            bus_oe   <= 1'b1;
            bus_dout <= next_addr[BUS_W-1:0];
            wdata_sh <= wdata_sh >> BUS_W;
          end else begin
            state         <= ST_IDLE;
            bus_oe        <= 1'b0;
            dtr           <= 1'b1;
            bif.busy      <= 1'b0;
            bif.req_ready <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_biu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_biu_sequencer                                        |
// | Description: Self-checking bench for biu_sequencer. Each transaction |
// |              is expanded into a per-cycle expected bus trace from    |
// |              the bus-cycle rules, then driven and compared cycle by  |
// |              cycle; literal checks pin latency, data and addresses.  |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_biu_sequencer;

  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  biu_sequencer_if #(.ADDR_W(20), .CPU_W(16)) bif ();

  logic [19:0] addr_o;
  logic        ale, rd_n, wr_n, den_n, dtr, bus_ready, bus_oe;
  logic [7:0]  bus_din, bus_dout;

  biu_sequencer #(.ADDR_W(20), .CPU_W(16), .BUS_W(8), .MAX_WAIT(MAXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bif       (bif),
    .addr_o    (addr_o),
    .ale       (ale),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .den_n     (den_n),
    .dtr       (dtr),
    .bus_ready (bus_ready),
    .bus_din   (bus_din),
    .bus_dout  (bus_dout),
    .bus_oe    (bus_oe)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rdy_in;
    logic [7:0] din;
    bit busy, rreq, ale, rd_n, wr_n, den_n, dtr, oe, done, err;
    bit         chk_addr;
    logic [19:0] addr;
    bit         chk_dout;
    logic [7:0] dout;
    logic [15:0] rdata;
  } cyc_t;

  cyc_t        sched[$];
  logic [15:0] m_rdata;
  logic [19:0] obs_addr[$];
  int          wr_low;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t idle_rec();
    cyc_t c;
    c.rdy_in = 1'b1; c.din = 8'hEE;
    c.busy = 0; c.rreq = 1; c.ale = 0; c.rd_n = 1; c.wr_n = 1; c.den_n = 1;
    c.dtr = 1; c.oe = 0; c.done = 0; c.err = 0;
    c.chk_addr = 0; c.addr = '0; c.chk_dout = 0; c.dout = '0;
    c.rdata = m_rdata;
    return c;
  endfunction

  function automatic cyc_t reset_rec();
    cyc_t c;
    c = idle_rec();
    c.chk_addr = 1; c.addr = '0;
    return c;
  endfunction

  function automatic logic [19:0] obs_at(input int i);
    if (i < obs_addr.size()) return obs_addr[i];
    return 'x;
  endfunction

  task automatic compare(input cyc_t e, input string tag);
    chk({tag, " busy"},      32'(bif.busy),      32'(e.busy));
    chk({tag, " req_ready"}, 32'(bif.req_ready), 32'(e.rreq));
    chk({tag, " ale"},       32'(ale),           32'(e.ale));
    chk({tag, " rd_n"},      32'(rd_n),          32'(e.rd_n));
    chk({tag, " wr_n"},      32'(wr_n),          32'(e.wr_n));
    chk({tag, " den_n"},     32'(den_n),         32'(e.den_n));
    chk({tag, " dtr"},       32'(dtr),           32'(e.dtr));
    chk({tag, " bus_oe"},    32'(bus_oe),        32'(e.oe));
    chk({tag, " done"},      32'(bif.done),      32'(e.done));
    chk({tag, " err"},       32'(bif.err),       32'(e.err));
    chk({tag, " rdata"},     32'(bif.rdata),     32'(e.rdata));
    if (e.chk_addr) chk({tag, " addr_o"},   32'(addr_o),   32'(e.addr));
    if (e.chk_dout) chk({tag, " bus_dout"}, 32'(bus_dout), 32'(e.dout));
  endtask

  // Expand one transaction into its expected cycle trace: accept cycle,
  // then per beat T1, T2, (waits+1) T3 cycles, T4.
  task automatic build(input bit we, input bit byt, input logic [19:0] addr,
                       input logic [15:0] wdata, input int w0, input int w1,
                       input logic [7:0] d0, input logic [7:0] d1);
    int         nb;
    int         waits[2];
    logic [7:0] dins[2];
    logic [7:0] wb[2];
    cyc_t       c;
    bit         abort;
    sched.delete();
    waits[0] = w0; waits[1] = w1; dins[0] = d0; dins[1] = d1;
    wb[0] = wdata[7:0]; wb[1] = wdata[15:8];
    nb = byt ? 1 : 2;
    abort = 0;
    sched.push_back(idle_rec());
    for (int b = 0; b < nb && !abort; b++) begin
      logic [19:0] a;
      int          t3;
      a = addr + 20'(b);
      c = idle_rec();
      c.busy = 1; c.rreq = 0; c.ale = 1; c.dtr = we; c.oe = 1;
      c.chk_addr = 1; c.addr = a; c.chk_dout = 1; c.dout = a[7:0];
      sched.push_back(c);
      c.ale = 0; c.den_n = 0; c.rd_n = we; c.wr_n = !we; c.oe = we;
      c.chk_dout = we; c.dout = wb[b];
      sched.push_back(c);
      abort = waits[b] > MAXW;
      t3 = abort ? MAXW + 1 : waits[b] + 1;
      for (int i = 0; i < t3; i++) begin
        c.rdy_in = (i >= waits[b]);
        c.din    = c.rdy_in ? dins[b] : (8'h5A ^ 8'(i));
        sched.push_back(c);
      end
      if (!we && !abort) m_rdata[8*b +: 8] = dins[b];
      c.rdy_in = 1; c.din = 8'hEE; c.rd_n = 1; c.wr_n = 1; c.den_n = 1;
      c.done = (b == nb - 1) || abort; c.err = abort; c.rdata = m_rdata;
      sched.push_back(c);
    end
  endtask

  task automatic run(input string name, input bit we, input bit byt,
                     input logic [19:0] addr, input logic [15:0] wdata,
                     input int w0, input int w1, input logic [7:0] d0, input logic [7:0] d1,
                     input bit hold, input int rst_at,
                     output int lat, output logic [15:0] rd, output bit er);
    build(we, byt, addr, wdata, w0, w1, d0, d1);
    lat = -1; rd = 'x; er = 0;
    obs_addr.delete();
    wr_low = 0;
    for (int k = 0; k < sched.size(); k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        bif.req_valid = 1'b1; bif.req_we = we; bif.req_byte = byt;
        bif.req_addr = addr; bif.req_wdata = wdata;
      end else if (k == 1) begin
        // Garbage on the request lines while busy must be ignored.
        bif.req_valid = hold; bif.req_we = ~we; bif.req_byte = ~byt;
        bif.req_addr = ~addr; bif.req_wdata = ~wdata;
      end
      bus_ready = sched[k].rdy_in;
      bus_din   = sched[k].din;
      @(negedge clk);
      compare(sched[k], $sformatf("%s c%0d", name, k));
      if (ale) obs_addr.push_back(addr_o);
      if (!wr_n) wr_low++;
      if (bif.done && lat < 0) begin
        lat = k; rd = bif.rdata; er = bif.err;
      end
      if (k == rst_at) begin
        #2 rst = 1'b0;
        m_rdata = '0;
        #1 compare(reset_rec(), $sformatf("%s async_rst", name));
        @(posedge clk); #1;
        compare(reset_rec(), $sformatf("%s held_rst", name));
        bif.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [15:0] rd;
    bit          er;
    bif.req_valid = 0; bif.req_we = 0; bif.req_byte = 0;
    bif.req_addr = '0; bif.req_wdata = '0;
    bus_ready = 0; bus_din = '0; m_rdata = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare(reset_rec(), "reset");
    chk("reset req_ready lit", 32'(bif.req_ready), 32'd1);
    rst = 1'b1;

    run("rd_word", 0, 0, 20'h12345, 16'h0000, 0, 0, 8'h34, 8'h12, 0, -1, lat, rd, er);
    chk("rd_word latency", lat, 8);
    chk("rd_word rdata lit", 32'(rd), 32'h1234);
    chk("rd_word err lit", 32'(er), 0);
    chk("rd_word addr0 lit", 32'(obs_at(0)), 32'h12345);
    chk("rd_word addr1 lit", 32'(obs_at(1)), 32'h12346);

    run("wr_word", 1, 0, 20'hFFFFF, 16'hBEEF, 0, 0, 8'h00, 8'h00, 0, -1, lat, rd, er);
    chk("wr_word latency", lat, 8);
    chk("wr_word addr0 lit", 32'(obs_at(0)), 32'hFFFFF);
    chk("wr_word addr1 wrap lit", 32'(obs_at(1)), 32'h00000);
    chk("wr_word wr_n low cycles", wr_low, 4);

    run("rd_byte_ws", 0, 1, 20'h00100, 16'h0000, 3, 0, 8'hA5, 8'h00, 0, -1, lat, rd, er);
    chk("rd_byte_ws latency", lat, 7);
    chk("rd_byte_ws rdata lit", 32'(rd), 32'h12A5);

    run("rd_abort", 0, 0, 20'h00200, 16'h0000, 100, 0, 8'h99, 8'h98, 0, -1, lat, rd, er);
    chk("rd_abort latency", lat, 8);
    chk("rd_abort err lit", 32'(er), 1);
    chk("rd_abort rdata kept", 32'(rd), 32'h12A5);
    chk("rd_abort beats", obs_addr.size(), 1);

    run("wr_byte", 1, 1, 20'h0ABCD, 16'h5A77, 1, 0, 8'h00, 8'h00, 0, -1, lat, rd, er);
    chk("wr_byte latency", lat, 5);
    chk("wr_byte wr_n low cycles", wr_low, 3);

    run("rd_ws_limit", 0, 0, 20'h00300, 16'h0000, 0, 4, 8'hC3, 8'h3C, 0, -1, lat, rd, er);
    chk("rd_ws_limit latency", lat, 12);
    chk("rd_ws_limit err lit", 32'(er), 0);
    chk("rd_ws_limit rdata lit", 32'(rd), 32'h3CC3);

    run("wr_reset", 1, 0, 20'h00400, 16'h1357, 0, 0, 8'h00, 8'h00, 0, 2, lat, rd, er);

    run("rd_after_rst", 0, 0, 20'h00500, 16'h0000, 0, 0, 8'h11, 8'h22, 0, -1, lat, rd, er);
    chk("rd_after_rst latency", lat, 8);
    chk("rd_after_rst rdata lit", 32'(rd), 32'h2211);

    run("hold_rd", 0, 0, 20'h00600, 16'h0000, 0, 0, 8'hAA, 8'h55, 1, -1, lat, rd, er);
    run("hold_wr", 1, 0, 20'h00700, 16'hCAFE, 0, 0, 8'h00, 8'h00, 1, -1, lat, rd, er);
    chk("hold_wr latency", lat, 8);
    run("hold_byte", 0, 1, 20'h00800, 16'h0000, 0, 0, 8'h0F, 8'h00, 0, -1, lat, rd, er);
    chk("hold_byte latency", lat, 4);
    chk("hold_byte rdata lit", 32'(rd), 32'h550F);

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      compare(idle_rec(), $sformatf("idle c%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/biu_sequencer.md
BIU_SEQUENCER -- requirements
Module: biu_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, external address width.
REQ-002 SHALL have parameter CPU_W, default 16, core-side data width.
REQ-003 SHALL have parameter BUS_W, default 8, external data width; CPU_W SHALL be a multiple of BUS_W; BEATS = CPU_W/BUS_W.
REQ-004 SHALL have parameter MAX_WAIT, default 0, wait-state limit (0 = unlimited).
REQ-005 clk  in  1  clock, rising-edge; rst  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  core requests a transfer; req_ready  out  1  request accepted this cycle.
REQ-007 req_we  in  1  1 = write; req_byte  in  1  1 = single-beat transfer.
REQ-008 req_addr  in  ADDR_W  start address; req_wdata  in  CPU_W  write data, beat 0 in LSBs.
REQ-009 busy  out  1  transfer in progress (core stall); done  out  1  one-cycle completion pulse.
REQ-010 rdata  out  CPU_W  assembled read data; err  out  1  timeout flag, valid with done.
REQ-011 addr_o  out  ADDR_W  bus address; ale  out  1  address latch enable.
REQ-012 rd_n, wr_n, den_n  out  1 each  active-low strobes; dtr  out  1  1 = CPU drives bus.
REQ-013 bus_ready  in  1  slave ready; bus_din  in  BUS_W; bus_dout  out  BUS_W; bus_oe  out  1.

Function
REQ-014 States: IDLE, T1, T2, T3, T4; T3 SHALL double as wait state TW.
REQ-015 req_ready = (state==IDLE); when req_valid & req_ready, the next edge latches addr/we/byte/wdata, clears beat and wait counters, and enters T1.
REQ-016 Beat count: 1 if req_byte, else BEATS.
REQ-017 T1: ale=1, bus_oe=1, bus_dout=addr_o[BUS_W-1:0], dtr=req_we; addr_o = latched addr + beat, modulo 2^ADDR_W, held stable T1..T4.
REQ-018 T2, T3: den_n=0; read: rd_n=0, dtr=0, bus_oe=0; write: wr_n=0, dtr=1, bus_oe=1, bus_dout=wdata[beat*BUS_W +: BUS_W].
REQ-019 T3: if bus_ready=1, go to T4, and on reads capture bus_din into rdata[beat*BUS_W +: BUS_W] on that edge; otherwise stay in T3 and increment the wait counter.
REQ-020 With MAX_WAIT>0, the wait counter reaching MAX_WAIT while bus_ready=0 SHALL force T4 with an abort flag; remaining beats are skipped.
REQ-021 T4: strobes high, den_n=1, bus_oe held for writes; beat++; go to T1 if more beats and no abort, else IDLE.
REQ-022 done=1 for exactly the final T4 cycle; err=abort in that cycle, else 0; rdata is stable from done until the next acceptance.
REQ-023 busy=1 in T1..T4; zero-wait latency: 4 cycles per beat; a word transfer gives done 8 cycles after acceptance.
REQ-024 req_valid during busy is ignored, with no queueing; back-to-back requests SHALL NOT overlap; the next acceptance is earliest in the IDLE cycle after done.
REQ-025 Unlatched rdata bytes (byte mode or abort) SHALL retain their previous values.

Reset
REQ-026 rst low SHALL force IDLE immediately, including mid-transfer: rd_n=wr_n=den_n=1, ale=0, dtr=1, bus_oe=0, busy=done=err=0, req_ready=1, addr_o=0, rdata=0, counters=0.

Structure
REQ-027 Package biu_pkg SHALL hold the state encoding enum and the derived BEATS/counter-width helpers.
REQ-028 One sub-module, biu_counter (parametrised width, clr/inc), SHALL be instantiated twice: for the beat count and the wait count.

Verification
REQ-029 Word read, addr 0x12345, bus_din 0x34 then 0x12, bus_ready=1 -> addr_o 0x12345/0x12346, done 8 cycles after acceptance, rdata=0x1234, err=0.
REQ-030 Word write 0xBEEF, addr 0xFFFFF -> bus_dout 0xEF then 0xBE, second addr_o=0x00000 (wrap), wr_n low 2 cycles per beat.
REQ-031 Byte read with bus_ready low 3 cycles in T3 -> T3 held 4 cycles, done at cycle 7 after acceptance, only rdata[7:0] updated.
REQ-032 MAX_WAIT=4, bus_ready stuck low -> abort after 4 waits, done=1 with err=1, no second beat, return to IDLE.
REQ-033 rst asserted in T2 of a write -> all outputs at reset values asynchronously; the next request completes normally.
REQ-034 req_valid held continuously -> one transfer per done, req_ready high only in IDLE, no strobe overlap between transfers.
